// File: rtl/program_loader_if.sv
// Interface for the boot program loader.
// Groups the UART byte stream, the reload strobe and the instruction RAM
// write port together with the loader status outputs.
//   master : stream source / RAM-side observer (drives rx_*, reload)
//   slave  : program_loader (drives wr_*/addr/data, core_run, load_err, words_loaded)
interface program_loader_if #(
  parameter int unsigned LOGWIDTH = 5
);
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                reload;
  logic                wr_en_instr;
  logic [31:0]         addr_in_instr;
  logic [31:0]         data_in_instr;
  logic                core_run;
  logic                load_err;
  logic [LOGWIDTH:0]   words_loaded;

  modport master (
    output rx_valid, rx_data, reload,
    input  wr_en_instr, addr_in_instr, data_in_instr, core_run, load_err, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output wr_en_instr, addr_in_instr, data_in_instr, core_run, load_err, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time sequencer for the instruction RAM write port.
// Assembles little-endian 32-bit words from a UART byte stream: a 4-byte word
// count N followed by N words. Each word is written to consecutive instruction
// RAM word addresses; core_run is raised once the whole image is committed.
// Ports:
//   clk   : system clock, posedge
//   rstn  : synchronous active-low reset
//   bus   : program_loader_if.slave (rx_valid/rx_data/reload in;
//           wr_en_instr/addr_in_instr/data_in_instr/core_run/load_err/words_loaded out)
module program_loader #(
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned LOGWIDTH  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  program_loader_if.slave   bus
);

  typedef enum logic [1:0] {HEADER, LOAD, DONE, ERROR} state_e;

  state_e              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  // Only bytes 0..2 are stored; byte 3 is taken straight from rx_data.
  logic [23:0]         shift_q, shift_d;
  logic [LOGWIDTH-1:0] word_idx_q, word_idx_d;
  logic [LOGWIDTH:0]   n_q, n_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                core_run_q, core_run_d;
  logic                load_err_q, load_err_d;
  logic [LOGWIDTH:0]   words_q, words_d;

  logic [31:0]         word_w;
  logic                byte_ok;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_idx_d = word_idx_q;
    n_d        = n_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    core_run_d = (state_q == DONE);
    load_err_d = load_err_q;
    words_d    = words_q;

    word_w  = {bus.rx_data, shift_q};
    byte_ok = bus.rx_valid && ((state_q == HEADER) || (state_q == LOAD));

    if (bus.reload) begin
      // reload wins over a coincident byte and any write it would complete
      state_d    = HEADER;
      byte_cnt_d = '0;
      word_idx_d = '0;
      words_d    = '0;
      core_run_d = 1'b0;
      load_err_d = 1'b0;
    end else if (byte_ok) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q != 2'd3) begin
        shift_d[8*byte_cnt_q +: 8] = bus.rx_data;
      end else if (state_q == HEADER) begin
        word_idx_d = '0;
        words_d    = '0;
        if (word_w == 32'd0) begin
          state_d = DONE;
        end else if (word_w > 32'(MAX_WORDS)) begin
          state_d    = ERROR;
          load_err_d = 1'b1;
        end else begin
          state_d = LOAD;
          n_d     = word_w[LOGWIDTH:0];
        end
      end else begin
        wr_en_d                = 1'b1;
        addr_d                 = '0;
        addr_d[LOGWIDTH+1:2]   = word_idx_q;
        data_d                 = word_w;
        words_d                = {1'b0, word_idx_q} + (LOGWIDTH+1)'(1);
        // Last word: hold word_idx so it never passes MAX_WORDS-1.
        if (words_d == n_q) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + LOGWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= HEADER;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_idx_q <= '0;
      n_q        <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_run_q <= 1'b0;
      load_err_q <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_idx_q <= word_idx_d;
      n_q        <= n_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_run_q <= core_run_d;
      load_err_q <= load_err_d;
      words_q    <= words_d;
    end
  end

  assign bus.wr_en_instr   = wr_en_q;
  assign bus.addr_in_instr = addr_q;
  assign bus.data_in_instr = data_q;
  assign bus.core_run      = core_run_q;
  assign bus.load_err      = load_err_q;
  assign bus.words_loaded  = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: cycle-by-cycle vector table plus a
// gapped-stream / mid-word reset sequence.
module tb_program_loader;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  program_loader_if #(.LOGWIDTH(5)) bus ();

  program_loader #(.MAX_WORDS(32), .LOGWIDTH(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        rstn;
    logic        rv;
    logic [7:0]  rd;
    logic        rl;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        run;
    logic        err;
    logic [5:0]  words;
  } vec_t;

  vec_t        vecs[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;
  localparam logic [31:0] W2 = 32'h4433_2211;
  localparam logic [31:0] W3 = 32'hDDCC_BBAA;
  localparam logic [31:0] W4 = 32'h4030_2010;
  localparam logic [31:0] W5 = 32'h0807_0605;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic l,
                              input logic wr, input logic [31:0] a, input logic [31:0] dt,
                              input logic run, input logic err, input logic [5:0] w);
    vec_t x;
    x.rstn = r; x.rv = v; x.rd = d; x.rl = l;
    x.wr = wr; x.addr = a; x.data = dt; x.run = run; x.err = err; x.words = w;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Apply inputs at negedge, sample outputs 1 time unit after the next posedge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    rstn = r; bus.rx_valid = v; bus.rx_data = d; bus.reload = l;
    @(posedge clk);
    #1;
    if (bus.wr_en_instr === 1'b1) begin
      wr_addr_q.push_back(bus.addr_in_instr);
      wr_data_q.push_back(bus.data_in_instr);
    end
  endtask

  task automatic send_gap(input logic [7:0] b);
    int unsigned g;
    g = $urandom_range(0, 5);
    repeat (g) drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, b, 1'b0);
  endtask

  // header / word byte helpers for the table: byte with rx_valid, idle, reload
  function automatic vec_t b(input logic [7:0] d, input logic wr, input logic [31:0] a,
                             input logic [31:0] dt, input logic run, input logic err,
                             input logic [5:0] w);
    return mk(1'b1, 1'b1, d, 1'b0, wr, a, dt, run, err, w);
  endfunction

  initial begin
    logic [7:0] stream [12];
    rstn = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.reload = 1'b0;

    // reset, bytes offered during reset are ignored
    vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 0, 0, 0));
    // N=2, back-to-back bytes
    vecs.push_back(b(8'h02, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h78, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h56, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h34, 0, 0, 0, 0, 0, 0));
    vecs.push_back(b(8'h12, 1, 0, W0, 0, 0, 1));
    vecs.push_back(b(8'hEF, 0, 0, W0, 0, 0, 1));
    vecs.push_back(b(8'hBE, 0, 0, W0, 0, 0, 1));
    vecs.push_back(b(8'hAD, 0, 0, W0, 0, 0, 1));
    vecs.push_back(b(8'hDE, 1, 4, W1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 4, W1, 1, 0, 2));
    vecs.push_back(b(8'h99, 0, 4, W1, 1, 0, 2));
    // N=0: DONE with no writes, later bytes ignored
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 4, W1, 1, 0, 0));
    vecs.push_back(b(8'h55, 0, 4, W1, 1, 0, 0));
    // N=33 rejected; bytes ignored until reload
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h21, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 1, 0));
    vecs.push_back(b(8'h01, 0, 4, W1, 0, 1, 0));
    vecs.push_back(b(8'h02, 0, 4, W1, 0, 1, 0));
    vecs.push_back(b(8'h03, 0, 4, W1, 0, 1, 0));
    vecs.push_back(b(8'h04, 0, 4, W1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 4, W1, 0, 0, 0));
    // N=1 after error recovery
    vecs.push_back(b(8'h01, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h11, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h22, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h33, 0, 4, W1, 0, 0, 0));
    vecs.push_back(b(8'h44, 1, 0, W2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, W2, 1, 0, 1));
    // N=3, reload after 1.5 words (coincident byte dropped), then N=1
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'h03, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'hAA, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'hBB, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'hCC, 0, 0, W2, 0, 0, 0));
    vecs.push_back(b(8'hDD, 1, 0, W3, 0, 0, 1));
    vecs.push_back(b(8'h01, 0, 0, W3, 0, 0, 1));
    vecs.push_back(b(8'h02, 0, 0, W3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h01, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h10, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h20, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h30, 0, 0, W3, 0, 0, 0));
    vecs.push_back(b(8'h40, 1, 0, W4, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, W4, 1, 0, 1));
    // reload coincident with 4th byte of a word suppresses the write
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h02, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h01, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h02, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h03, 0, 0, W4, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 1, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h01, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h05, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h06, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h07, 0, 0, W4, 0, 0, 0));
    vecs.push_back(b(8'h08, 1, 0, W5, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, W5, 1, 0, 1));
    // N=32 (boundary) accepted, then N=0x01000001 rejected via upper byte
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h20, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W5, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, W5, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h01, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h00, 0, 0, W5, 0, 0, 0));
    vecs.push_back(b(8'h01, 0, 0, W5, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, W5, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].rv, vecs[i].rd, vecs[i].rl);
      chk($sformatf("v%0d wr_en", i),  32'(bus.wr_en_instr),   32'(vecs[i].wr));
      chk($sformatf("v%0d addr", i),   bus.addr_in_instr,      vecs[i].addr);
      chk($sformatf("v%0d data", i),   bus.data_in_instr,      vecs[i].data);
      chk($sformatf("v%0d run", i),    32'(bus.core_run),      32'(vecs[i].run));
      chk($sformatf("v%0d err", i),    32'(bus.load_err),      32'(vecs[i].err));
      chk($sformatf("v%0d words", i),  32'(bus.words_loaded),  32'(vecs[i].words));
    end

    // Gapped stream with a reset in the middle of the first word
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_addr_q.delete();
    wr_data_q.delete();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_gap(stream[i]);
    drive(1'b0, 1'b1, 8'h34, 1'b0);
    chk("midreset writes", 32'(wr_addr_q.size()), 32'd0);
    chk("midreset data",   bus.data_in_instr,     32'd0);
    chk("midreset words",  32'(bus.words_loaded), 32'd0);
    chk("midreset run",    32'(bus.core_run),     32'd0);
    for (int i = 0; i < 12; i++) send_gap(stream[i]);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("gap writes", 32'(wr_addr_q.size()), 32'd2);
    chk("gap addr0", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hFFFF_FFFF, 32'd0);
    chk("gap data0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFF_FFFF, W0);
    chk("gap addr1", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hFFFF_FFFF, 32'd4);
    chk("gap data1", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hFFFF_FFFF, W1);
    chk("gap run",   32'(bus.core_run),     32'd1);
    chk("gap words", 32'(bus.words_loaded), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
